// File: rtl/cdc_bus_tx.sv
// Source-side transmitter for a two-phase toggle request/acknowledge bus crossing.
// Holds the accepted word on xfer_data until the synchronised acknowledge matches xfer_req.
module cdc_bus_tx #(
   parameter int NUMSTGS = 2,
   parameter int DATAWTH = 8,
   parameter int TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               src_valid,
   input  logic [DATAWTH-1:0] src_data,
   output logic               src_ready,
   output logic               xfer_req,
   output logic [DATAWTH-1:0] xfer_data,
   input  logic               ack_async,
   output logic               done,
   output logic               err_proto,
   output logic               err_timeout,
   input  logic               err_clr
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

   state_t               state_r, state_nxt_s;
   logic [NUMSTGS-1:0]   sync_r;
   logic                 ack_sync_s;
   logic [15:0]          cnt_r, cnt_nxt_s;
   logic                 req_r, req_nxt_s;
   logic [DATAWTH-1:0]   data_r, data_nxt_s;
   logic                 done_r, done_nxt_s;
   logic                 eproto_r, eproto_nxt_s;
   logic                 etmo_r, etmo_nxt_s;
   logic                 set_proto_s, set_tmo_s;

   // Plain flop chain resynchronising the destination's toggle acknowledge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[NUMSTGS-2:0], ack_async};
      end
   end

   assign ack_sync_s = sync_r[NUMSTGS-1];

   // Next-state, handshake and error-flag logic
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      req_nxt_s    = req_r;
      data_nxt_s   = data_r;
      done_nxt_s   = 1'b0;
      set_proto_s  = 1'b0;
      set_tmo_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (ack_sync_s != req_r) begin
               set_proto_s = 1'b1;
            end else begin
               set_proto_s = 1'b0;
            end
            if (src_valid) begin
               data_nxt_s  = src_data;
               req_nxt_s   = ~req_r;
               cnt_nxt_s   = 16'd0;
               state_nxt_s = WAIT_ACK;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_ACK: begin
            if (ack_sync_s == req_r) begin
               state_nxt_s = IDLE;
               done_nxt_s  = 1'b1;
            end else if (cnt_r < TMO_LIMIT) begin
               // Flag only on the edge the count reaches the limit, so err_clr can drop it while still stuck
               cnt_nxt_s = cnt_r + 16'd1;
               set_tmo_s = ((cnt_r + 16'd1) == TMO_LIMIT);
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
      eproto_nxt_s = set_proto_s | (eproto_r & ~err_clr);
      etmo_nxt_s   = set_tmo_s   | (etmo_r   & ~err_clr);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= 16'd0;
         req_r    <= 1'b0;
         data_r   <= '0;
         done_r   <= 1'b0;
         eproto_r <= 1'b0;
         etmo_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         req_r    <= req_nxt_s;
         data_r   <= data_nxt_s;
         done_r   <= done_nxt_s;
         eproto_r <= eproto_nxt_s;
         etmo_r   <= etmo_nxt_s;
      end
   end

   assign src_ready   = (state_r == IDLE);
   assign xfer_req    = req_r;
   assign xfer_data   = data_r;
   assign done        = done_r;
   assign err_proto   = eproto_r;
   assign err_timeout = etmo_r;

endmodule

// File: tb/tb_cdc_bus_tx.sv
// Randomised and directed bench for cdc_bus_tx, checked every cycle against
// a transaction-level reference model of the toggle handshake.
module tb_cdc_bus_tx;

   localparam int NS  = 2;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          src_valid = 1'b0;
   logic [DW-1:0] src_data = '0;
   logic          src_ready;
   logic          xfer_req;
   logic [DW-1:0] xfer_data;
   logic          ack_async;
   logic          done;
   logic          err_proto;
   logic          err_timeout;
   logic          err_clr = 1'b0;

   logic          loop = 1'b1;
   logic          ack_man = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   bit            m_busy;
   bit            m_req;
   bit [DW-1:0]   m_data;
   int            m_wait;
   bit            m_done;
   bit            m_ep;
   bit            m_et;
   bit            m_hist[$];

   assign ack_async = loop ? xfer_req : ack_man;

   always #5 clk = ~clk;

   cdc_bus_tx #(.NUMSTGS(NS), .DATAWTH(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
      .src_ready(src_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
      .ack_async(ack_async), .done(done), .err_proto(err_proto),
      .err_timeout(err_timeout), .err_clr(err_clr)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_req = 1'b0; m_data = '0; m_wait = 0;
      m_done = 1'b0; m_ep = 1'b0; m_et = 1'b0;
      m_hist.delete();
      for (int i = 0; i < NS; i++) m_hist.push_back(1'b0);
   endtask

   // One clock edge of the handshake: ack seen NS edges late, word held while busy
   task automatic model_step(input bit v, input bit [DW-1:0] d, input bit a, input bit clr);
      bit seen, sp, st;
      seen = m_hist[0];
      sp = 1'b0; st = 1'b0; m_done = 1'b0;
      if (!m_busy) begin
         sp = (seen != m_req);
         if (v) begin
            m_data = d; m_req = !m_req; m_wait = 0; m_busy = 1'b1;
         end
      end else if (seen == m_req) begin
         m_busy = 1'b0; m_done = 1'b1;
      end else if (m_wait < TMO) begin
         m_wait++;
         st = (m_wait == TMO);
      end
      m_ep = sp || (m_ep && !clr);
      m_et = st || (m_et && !clr);
      void'(m_hist.pop_front());
      m_hist.push_back(a);
   endtask

   task automatic compare_all();
      check_eq("src_ready",   src_ready,   !m_busy);
      check_eq("xfer_req",    xfer_req,    m_req);
      check_eq("xfer_data",   xfer_data,   m_data);
      check_eq("done",        done,        m_done);
      check_eq("err_proto",   err_proto,   m_ep);
      check_eq("err_timeout", err_timeout, m_et);
   endtask

   // Called at a falling edge: drive inputs, advance the model, check after the next rising edge
   task automatic cyc(input bit v, input bit [DW-1:0] d, input bit clr);
      bit a;
      src_valid = v; src_data = d; err_clr = clr;
      a = loop ? m_req : ack_man;
      model_step(v, d, a, clr);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      bit [DW-1:0] b2b[3];
      int idx;
      b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33;
      model_reset();

      // reset state
      #12;
      check_eq("rst_xfer_req", xfer_req, 1'b0);
      check_eq("rst_xfer_data", xfer_data, 8'h00);
      check_eq("rst_done", done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      compare_all();
      @(negedge clk);

      // single loopback word
      cyc(1'b1, 8'hA5, 1'b0);
      check_eq("a5_data", xfer_data, 8'hA5);
      check_eq("a5_req", xfer_req, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);

      // back-to-back with src_valid held
      idx = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(idx < 3, (idx < 3) ? b2b[idx] : 8'h00, 1'b0);
         if (m_busy && src_ready == 1'b0 && xfer_data == b2b[(idx < 3) ? idx : 2] && idx < 3
             && m_data == b2b[idx]) idx++;
      end
      check_eq("b2b_count", idx, 3);

      // delayed acknowledge with churning src_data
      loop = 1'b0; ack_man = m_req;
      cyc(1'b1, 8'h5C, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'($urandom), 8'($urandom), 1'b0);
      check_eq("dly_hold", xfer_data, 8'h5C);
      ack_man = m_req;
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);

      // timeout with ack stuck, then late ack, then clear
      cyc(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < TMO; i++) cyc(1'b0, 8'h00, 1'b0);
      check_eq("tmo_flag", err_timeout, 1'b1);
      check_eq("tmo_busy", src_ready, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
      ack_man = m_req;
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      check_eq("tmo_clr", err_timeout, 1'b0);

      // spurious ack in IDLE; clear loses to a persisting mismatch
      ack_man = !m_req;
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
      check_eq("proto_set", err_proto, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b1);
      check_eq("proto_hold", err_proto, 1'b1);
      ack_man = m_req;
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      check_eq("proto_clr", err_proto, 1'b0);

      // async reset in the middle of a wait
      loop = 1'b1;
      cyc(1'b1, 8'h77, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_req", xfer_req, 1'b0);
      check_eq("mid_rst_data", xfer_data, 8'h00);
      check_eq("mid_rst_done", done, 1'b0);
      check_eq("mid_rst_ep", err_proto, 1'b0);
      check_eq("mid_rst_et", err_timeout, 1'b0);
      model_reset();
      ack_man = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rel_ready", src_ready, 1'b1);
      @(negedge clk);

      // random traffic, switching between loopback and a randomly late destination
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) begin
            loop = 1'($urandom);
            ack_man = m_req;
         end
         if (!loop) begin
            if (m_busy && $urandom_range(0, 7) == 0) ack_man = m_req;
            else if (!m_busy && $urandom_range(0, 99) == 0) ack_man = !ack_man;
         end
         cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
